// File: rtl/byte_serial_add32.sv
// Byte-serial W-bit adder reusing select_adder8 (LSB byte first); result in DONE after NBYTES RUN cycles.
// in_ready only in IDLE; DONE holds sum/cout until out_ready. Define BSA_SUB_EN to add the `sub` port (A-B).
module select_adder8 (
   output logic [7:0] s,
   output logic       co,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       ci
);
   logic [4:0] lo;
   logic [4:0] hi0;
   logic [4:0] hi1;

   // Upper nibble is precomputed for both carries; the low nibble's carry picks one.
   assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
   assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
   assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
   assign s   = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
   assign co  = lo[4] ? hi1[4] : hi0[4];
endmodule

module byte_serial_add32 #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] op_a,
   input  logic [8*NBYTES-1:0] op_b,
   input  logic                cin,
`ifdef BSA_SUB_EN
   input  logic                sub,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] sum,
   output logic                cout
);
   localparam int W = 8*NBYTES;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       state;
   state_t       state_nxt;
   logic [W-1:0] a_reg;
   logic [W-1:0] b_reg;
   logic         carry;
   logic [2:0]   idx;
   logic [7:0]   byte_s;
   logic         byte_co;
   logic         last;
   logic         sub_sel;

`ifdef BSA_SUB_EN
   assign sub_sel = sub;
`else
   assign sub_sel = 1'b0;
`endif

   assign last = (idx == 3'(NBYTES-1));

   select_adder8 u_add (
      .s  (byte_s),
      .co (byte_co),
      .a  (a_reg[8*idx +: 8]),
      .b  (b_reg[8*idx +: 8]),
      .ci (carry)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= op_a;
                  // Subtraction is A + ~B + 1, so cout=1 reads as "no borrow".
                  b_reg <= sub_sel ? ~op_b : op_b;
                  carry <= sub_sel | cin;
                  idx   <= '0;
               end
            end
            RUN: begin
               sum[8*idx +: 8] <= byte_s;
               carry           <= byte_co;
               idx             <= idx + 3'd1;
               if (last) cout <= byte_co;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_byte_serial_add32.sv
// Bench for byte_serial_add32: arithmetic/handshake model checked every cycle, plus literal anchor cases.
module tb_byte_serial_add32;
   localparam int NBYTES = 4;
   localparam int W      = 8*NBYTES;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         in_ready;
   logic         out_valid;
   logic         cout;
   logic [W-1:0] sum;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   byte_serial_add32 #(.NBYTES(NBYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .cin       (cin),
`ifdef BSA_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkw(input string name, input logic [W:0] act, input logic [W:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got {cout,sum}=%h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference arithmetic straight from the definition of add / subtract.
   function automatic logic [W:0] exp_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c, input logic s);
      logic [W:0] r;
      if (s) begin
         r[W-1:0] = a - b;
         r[W]     = (a >= b);
      end else begin
         r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      end
      return r;
   endfunction

   // Model: busy from accept until release; result visible NBYTES edges after the accept edge.
   logic       model_ok = 1'b0;
   logic       busy = 1'b0;
   int         cnt = 0;
   logic [W:0] pend = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         cnt      <= 0;
         model_ok <= 1'b1;
      end else if (!busy) begin
         if (in_valid) begin
            busy <= 1'b1;
            cnt  <= 0;
`ifdef BSA_SUB_EN
            pend <= exp_result(op_a, op_b, cin, sub);
`else
            pend <= exp_result(op_a, op_b, cin, 1'b0);
`endif
         end
      end else if (cnt < NBYTES) begin
         cnt <= cnt + 1;
      end else if (out_ready) begin
         busy <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk1("in_ready", in_ready, !busy);
         chk1("out_valid", out_valid, busy && (cnt == NBYTES));
         if (busy && (cnt == NBYTES)) chkw("result", {cout, sum}, pend);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
      int t = 0;
      while (!in_ready && t < 200) begin
         step();
         t++;
      end
      chk1("in_ready_seen", in_ready, 1'b1);
      op_a     = a;
      op_b     = b;
      cin      = c;
      sub      = s;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      op_a     = $urandom;
      op_b     = $urandom;
   endtask

   task automatic wait_valid(output int t);
      t = 0;
      while (!out_valid && t < 50) begin
         step();
         t++;
      end
      chk1("out_valid_seen", out_valid, 1'b1);
   endtask

   task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input logic s, input logic [W:0] lit);
      int t;
      out_ready = 1'b1;
      issue(a, b, c, s);
      wait_valid(t);
      chki("latency", t, NBYTES);
      chkw("literal", {cout, sum}, lit);
      chkw("model_pin", pend, lit);
      step();
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int  t;
      logic done;
      // Reset wins over a simultaneous in_valid.
      in_valid = 1'b1;
      op_a     = 32'hDEADBEEF;
      op_b     = 32'h01234567;
      repeat (3) step();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      chkw("rst_result", {cout, sum}, 33'h0_00000000);
      step();
      chk1("rst_no_capture", in_ready, 1'b1);

      directed(32'h00000005, 32'h0000000A, 1'b1, 1'b0, 33'h0_00000010);
      directed(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 33'h1_00000000);
      directed(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 1'b0, 33'h0_FEFEFEFF);
      directed(32'h80000000, 32'h80000000, 1'b0, 1'b0, 33'h1_00000000);

      // Backpressure: DONE holds while new operands are offered.
      out_ready = 1'b0;
      issue(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 1'b0);
      wait_valid(t);
      repeat (6) begin
         in_valid = 1'b1;
         op_a     = $urandom;
         op_b     = $urandom;
         chkw("hold_result", {cout, sum}, 33'h0_FEFEFEFF);
         chk1("hold_in_ready", in_ready, 1'b0);
         step();
      end
      in_valid = 1'b0;
      chkw("hold_result_end", {cout, sum}, 33'h0_FEFEFEFF);
      out_ready = 1'b1;
      step();
      chk1("release_in_ready", in_ready, 1'b1);
      chk1("release_out_valid", out_valid, 1'b0);

      // Reset in the middle of RUN discards the partial result.
      issue(32'h12345678, 32'h11111111, 1'b0, 1'b0);
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk1("midrst_in_ready", in_ready, 1'b1);
      chk1("midrst_out_valid", out_valid, 1'b0);
      chkw("midrst_result", {cout, sum}, 33'h0_00000000);
      directed(32'h12345678, 32'h11111111, 1'b0, 1'b0, 33'h0_23456789);

`ifdef BSA_SUB_EN
      directed(32'd100, 32'd200, 1'b1, 1'b1, 33'h0_FFFFFF9C);
      directed(32'd200, 32'd100, 1'b0, 1'b1, 33'h1_00000064);
      directed(32'd200, 32'd100, 1'b1, 1'b0, 33'h0_0000012D);
`endif

      // Randomized traffic with random backpressure and ignored in_valid while busy.
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 2)) step();
`ifdef BSA_SUB_EN
         issue(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
`else
         issue(pick_operand(), pick_operand(), 1'($urandom), 1'b0);
`endif
         t    = 0;
         done = 1'b0;
         while (!done && t < 100) begin
            out_ready = 1'($urandom);
            done      = out_valid && out_ready;
            in_valid  = done ? 1'b0 : 1'($urandom);
            op_a      = $urandom;
            op_b      = $urandom;
            step();
            t++;
         end
         in_valid = 1'b0;
         chk1("random_released", done, 1'b1);
      end

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
      $fatal(1);
   end
endmodule
